// File: rtl/ad9833_pkg.sv
// Shared constants and types for the AD9833 serial receiver: opcodes, control bit
// positions, register widths and the frame FSM state type.
package ad9833_pkg;
    localparam int WORD_W  = 16;
    localparam int FREQ_W  = 28;
    localparam int PHASE_W = 12;
    localparam int HALF_W  = 14;

    localparam logic [1:0] OP_CTRL = 2'b00;
    localparam logic [1:0] OP_F0   = 2'b01;
    localparam logic [1:0] OP_F1   = 2'b10;
    localparam logic [1:0] OP_PH   = 2'b11;

    localparam int CTRL_B28   = 13;
    localparam int CTRL_HLB   = 12;
    localparam int CTRL_RESET = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;
endpackage

// File: rtl/ad9833_sync.sv
// Multi-flop synchroniser for one asynchronous input, with a selectable reset value.
module ad9833_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= {STAGES{RST_VAL}};
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/ad9833_rx.sv
// AD9833 serial link receiver: oversamples fsync/sclk/sdata, deserialises 16-bit words
// MSB-first and decodes them into control, frequency and phase registers.
module ad9833_rx
    import ad9833_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fsync,
    input  logic        sclk,
    input  logic        sdata,
    output logic [15:0] word,
    output logic        word_valid,
    output logic [15:0] control_reg,
    output logic [27:0] freq0,
    output logic [27:0] freq1,
    output logic [11:0] phase0,
    output logic [11:0] phase1,
    output logic        freq_update,
    output logic        frame_err,
    output logic        busy
);
    logic fsync_s, sclk_s, sdata_s;
    logic sclk_prev;
    logic sclk_fall;

    ad9833_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_fsync (
        .clk(clk), .rst(rst), .d(fsync), .q(fsync_s)
    );
    ad9833_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
    );
    ad9833_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdata (
        .clk(clk), .rst(rst), .d(sdata), .q(sdata_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sclk_prev <= 1'b0;
        else     sclk_prev <= sclk_s;
    end

    assign sclk_fall = sclk_prev & ~sclk_s;
    assign busy      = ~fsync_s;

    // ---- Frame FSM / shifter: word and word_valid land one cycle after the 16th fall
    rx_state_t   state;
    logic [15:0] shreg;
    logic [3:0]  bit_cnt;
    logic [15:0] shreg_nxt;

    assign shreg_nxt = {shreg[14:0], sdata_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fsync_s) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    // fsync rising takes priority over a coincident sclk fall
                    if (fsync_s) begin
                        state     <= ST_IDLE;
                        bit_cnt   <= '0;
                        frame_err <= (bit_cnt != 4'd0);
                    end else if (sclk_fall) begin
                        shreg   <= shreg_nxt;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            word       <= shreg_nxt;
                            word_valid <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---- Decode stage: registers update the cycle after word_valid
    logic        pend_vld;
    logic        pend_sel;
    logic [13:0] pend_lsb;
    logic [1:0]  op;
    logic        is_f1;

    assign op    = word[15:14];
    assign is_f1 = (op == OP_F1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            control_reg <= '0;
            freq0       <= '0;
            freq1       <= '0;
            phase0      <= '0;
            phase1      <= '0;
            freq_update <= 1'b0;
            pend_vld    <= 1'b0;
            pend_sel    <= 1'b0;
            pend_lsb    <= '0;
        end else begin
            freq_update <= 1'b0;
            if (word_valid) begin
                case (op)
                    OP_CTRL: begin
                        control_reg <= word;
                        pend_vld    <= 1'b0;
                    end
                    OP_F0, OP_F1: begin
                        if (control_reg[CTRL_B28]) begin
                            if (pend_vld && (pend_sel == is_f1)) begin
                                if (is_f1) freq1 <= {word[13:0], pend_lsb};
                                else       freq0 <= {word[13:0], pend_lsb};
                                freq_update <= 1'b1;
                                pend_vld    <= 1'b0;
                            end else begin
                                pend_vld <= 1'b1;
                                pend_sel <= is_f1;
                                pend_lsb <= word[13:0];
                            end
                        end else begin
                            if (control_reg[CTRL_HLB]) begin
                                if (is_f1) freq1[27:14] <= word[13:0];
                                else       freq0[27:14] <= word[13:0];
                            end else begin
                                if (is_f1) freq1[13:0] <= word[13:0];
                                else       freq0[13:0] <= word[13:0];
                            end
                            freq_update <= 1'b1;
                        end
                    end
                    default: begin
                        if (word[13]) phase1 <= word[11:0];
                        else          phase0 <= word[11:0];
                    end
                endcase
            end
        end
    end
endmodule
